// File: rtl/smpl_queue.sv
// rtl/smpl_queue.sv - circular sample buffer replaying the last DEPTH samples to one FIR band engine
// Optional sticky drop flag output ovr is built when QUEUE_OVR_FLAG_EN is defined.
module smpl_queue #(
    parameter int DEPTH = 1021,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wrt_smpl,
    input  logic signed [WIDTH-1:0] new_smpl,
    output logic signed [WIDTH-1:0] smpl_out,
    output logic                    sequencing,
`ifdef QUEUE_OVR_FLAG_EN
    output logic                    ovr,
`endif
    output logic                    full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, IDLE, SEQ} state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           wptr, rptr, seq_cnt;
    logic [CW-1:0]           count;
    logic signed [WIDTH-1:0] mem [DEPTH];
    logic                    accept, rd_en, last_seq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        accept    = wrt_smpl && (state != SEQ);
        last_seq  = sequencing && (seq_cnt == PTR_LAST);
        // the first SEQ cycle (sequencing still low) prefetches entry 0
        rd_en     = (state == SEQ) && !last_seq;
        state_nxt = state;
        case (state)
            FILL:    if (wrt_smpl && (count == CW'(DEPTH - 1))) state_nxt = SEQ;
            IDLE:    if (wrt_smpl) state_nxt = SEQ;
            SEQ:     if (last_seq) state_nxt = IDLE;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= new_smpl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            seq_cnt    <= '0;
            sequencing <= 1'b0;
            smpl_out   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wptr <= ptr_inc(wptr);
                // oldest entry after this write sits at the advanced write pointer
                rptr <= ptr_inc(wptr);
                if (state == FILL) count <= count + 1'b1;
            end else if (rd_en) begin
                rptr <= ptr_inc(rptr);
            end
            if (rd_en) smpl_out <= mem[rptr];
            sequencing <= (state == SEQ) && !last_seq;
            seq_cnt    <= sequencing ? seq_cnt + 1'b1 : '0;
        end
    end

    assign full = (count == CW'(DEPTH));

`ifdef QUEUE_OVR_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovr <= 1'b0;
        else        ovr <= ovr | (wrt_smpl && (state == SEQ));
    end
`endif

endmodule

// File: tb/tb_smpl_queue.sv
// tb/tb_smpl_queue.sv - scoreboard bench for smpl_queue at DEPTH 1021, 4 and 1
module tb_smpl_queue;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               wrt  [N];
    logic signed [15:0] din  [N];
    logic signed [15:0] sout [N];
    logic               seqo [N];
    logic               fullo[N];
`ifdef QUEUE_OVR_FLAG_EN
    logic               ovro [N];
`endif

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int cnt[N], trig[N], full_e[N], ovr_e[N], last_out[N];
    bit trig_v[N], full_v[N], ovr_v[N];
    int hist[N][$];
    int expq[N][$];

    function automatic int dep(int g);
        return (g == 0) ? 1021 : (g == 1) ? 4 : 1;
    endfunction

    task automatic check_val(string tag, int obs, int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic monitor(int g);
        int  d = dep(g);
        bit  es;
        if (!rst_n) begin
            check_val($sformatf("rst_seq%0d", g), seqo[g], 0);
            check_val($sformatf("rst_full%0d", g), fullo[g], 0);
            check_val($sformatf("rst_out%0d", g), sout[g], 0);
            return;
        end
        es = trig_v[g] && (edge_cnt >= trig[g] + 1) && (edge_cnt <= trig[g] + d);
        check_val($sformatf("sequencing%0d", g), seqo[g], es);
        check_val($sformatf("full%0d", g), fullo[g], full_v[g] && (edge_cnt >= full_e[g]));
`ifdef QUEUE_OVR_FLAG_EN
        check_val($sformatf("ovr%0d", g), ovro[g], ovr_v[g] && (edge_cnt >= ovr_e[g]));
`endif
        if (es) begin
            if (expq[g].size() == 0) check_val($sformatf("replay_q%0d", g), expq[g].size(), 1);
            else last_out[g] = expq[g].pop_front();
        end
        check_val($sformatf("smpl_out%0d", g), sout[g], last_out[g]);
    endtask

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            smpl_queue #(.DEPTH((g == 0) ? 1021 : (g == 1) ? 4 : 1), .WIDTH(16)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .wrt_smpl   (wrt[g]),
                .new_smpl   (din[g]),
                .smpl_out   (sout[g]),
                .sequencing (seqo[g]),
`ifdef QUEUE_OVR_FLAG_EN
                .ovr        (ovro[g]),
`endif
                .full       (fullo[g])
            );
            always @(negedge clk) monitor(g);
        end
    endgenerate

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            cnt[g] = 0; trig_v[g] = 0; full_v[g] = 0; ovr_v[g] = 0;
            trig[g] = 0; full_e[g] = 0; ovr_e[g] = 0; last_out[g] = 0;
            hist[g].delete();
            expq[g].delete();
        end
    endtask

    task automatic push_replay(int g, int x);
        trig_v[g] = 1;
        trig[g]   = x;
        for (int k = 0; k < hist[g].size(); k++) expq[g].push_back(hist[g][k]);
    endtask

    // drive a write so that it is captured on edge number x
    task automatic wr_at(int g, int d, int x);
        logic signed [15:0] s;
        int dd = dep(g);
        while (edge_cnt < x - 1) @(negedge clk);
        #1;
        s = d[15:0];
        wrt[g] = 1'b1;
        din[g] = s;
        x = edge_cnt + 1;
        if (cnt[g] < dd) begin
            hist[g].push_back(int'(s));
            cnt[g]++;
            if (cnt[g] == dd) begin
                full_v[g] = 1;
                full_e[g] = x;
                push_replay(g, x);
            end
        end else if (trig_v[g] && (x <= trig[g] + dd + 1)) begin
            if (!ovr_v[g]) begin
                ovr_v[g] = 1;
                ovr_e[g] = x;
            end
        end else begin
            void'(hist[g].pop_front());
            hist[g].push_back(int'(s));
            push_replay(g, x);
        end
        @(posedge clk);
        #1 wrt[g] = 1'b0;
    endtask

    task automatic wr(int g, int d);
        wr_at(g, d, edge_cnt + 1);
    endtask

    task automatic wait_until(int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    int t;

    initial begin
        for (int g = 0; g < N; g++) begin
            wrt[g] = 1'b0;
            din[g] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 1; i <= 1021; i++) wr(0, i);
        t = trig[0];
        wait_until(t + 1021 + 3);
        wr(0, 1022);
        t = trig[0];
        wait_until(t + 1021 + 3);
        wr(0, 1023);
        t = trig[0];
        wr_at(0, 32'h7FFF, t + 502);
        wr_at(0, 111, t + 1021 + 1);
        wr_at(0, 32'h8000, t + 1021 + 2);
        t = trig[0];

        wait_until(t + 301);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_val("async_rst_seq", seqo[0], 0);
        check_val("async_rst_full", fullo[0], 0);
        check_val("async_rst_out", sout[0], 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 1021; i++) wr(0, 2001 + i);
        t = trig[0];
        wait_until(t + 1021 + 3);

        wr(1, -1); wr(1, 2); wr(1, -3); wr(1, 4);
        t = trig[1];
        wait_until(t + 4 + 3);
        wr(1, 5);
        wr(1, 99);
        t = trig[1];
        wr_at(1, -6, t + 4 + 2);
        t = trig[1];
        wait_until(t + 4 + 3);

        wr(2, 7);
        wr(2, -9);
        t = trig[2];
        wr_at(2, -9, t + 1 + 2);
        t = trig[2];
        wr_at(2, 12345, t + 1 + 2);
        t = trig[2];
        wait_until(t + 4);

        repeat (5) @(negedge clk);
        for (int g = 0; g < N; g++)
            check_val($sformatf("replay_drained%0d", g), expq[g].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
